// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage and its skid buffer:
// default datapath width, instruction word size, the no-op instruction used
// as the bubble value, and the fetch state encoding.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int INSTR_SIZE = 32;

   // ADDI x0,x0,0. Must never be zero: opcode 0 decodes as illegal.
   localparam logic [INSTR_SIZE-1:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,  // requesting (or ready to request) the word at pc
      ST_FULL = 2'd1,  // skid holds a word, output stalled, no request
      ST_DROP = 2'd2   // waiting out a stale request after a redirect
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry {instr, pc} holding buffer for a stalled pipeline stage.
//   i_clk, i_rst        : clock, synchronous active-high reset (empties buffer)
//   i_load              : capture i_instr/i_pc and mark full
//   i_unload            : mark empty (contents are read on o_instr/o_pc)
//   i_clear             : discard contents; wins over load/unload
//   o_full              : buffer holds a valid entry
//   o_instr, o_pc       : stored entry
// -----------------------------------------------------------------------------
module fetch_skid_buf
   import instr_fetch_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic                  i_unload,
   input  logic                  i_clear,
   input  logic [INSTR_SIZE-1:0] i_instr,
   input  logic [XLEN-1:0]       i_pc,
   output logic                  o_full,
   output logic [INSTR_SIZE-1:0] o_instr,
   output logic [XLEN-1:0]       o_pc
);

   logic                  full_q,  full_d;
   logic [INSTR_SIZE-1:0] instr_q, instr_d;
   logic [XLEN-1:0]       pc_q,    pc_d;

   always_comb begin
      full_d  = full_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (i_clear) begin
         full_d = 1'b0;
      end else if (i_load) begin
         full_d  = 1'b1;
         instr_d = i_instr;
         pc_d    = i_pc;
      end else if (i_unload) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         full_q <= 1'b0;
      end else begin
         full_q <= full_d;
      end
   end

   // Payload needs no reset: it is only observed while full_q is set.
   always_ff @(posedge i_clk) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

   assign o_full  = full_q;
   assign o_instr = instr_q;
   assign o_pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage feeding decode. Owns the PC, issues single-
// outstanding req/ack reads to instruction memory, presents the registered
// instruction and its PC, absorbs decode stalls with a 1-entry skid buffer,
// and restarts on redirect (branch, JAL/JALR, trap entry).
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_Stall                  : decode cannot accept; output is held
//   i_Redirect/i_Redirect_PC : flush and refetch from target (bits [1:0] ignored)
//   o_IM_req/o_IM_addr       : memory request, held stable until i_IM_ack
//   i_IM_ack/i_IM_data       : read completion and fetched word
//   o_Instr/o_PC/o_Valid     : instruction to decode (NOP_INSTR when invalid)
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                    XLEN      = XLEN_DEF,
   parameter logic [XLEN-1:0]       RESET_PC  = '0,
   parameter logic [INSTR_SIZE-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_Stall,
   input  logic                  i_Redirect,
   input  logic [XLEN-1:0]       i_Redirect_PC,
   output logic                  o_IM_req,
   output logic [XLEN-1:0]       o_IM_addr,
   input  logic                  i_IM_ack,
   input  logic [INSTR_SIZE-1:0] i_IM_data,
   output logic [INSTR_SIZE-1:0] o_Instr,
   output logic [XLEN-1:0]       o_PC,
   output logic                  o_Valid
);

   fetch_state_e          state_q, state_d;
   logic [XLEN-1:0]       pc_q, pc_d;
   logic [XLEN-1:0]       drop_pc_q, drop_pc_d;
   logic                  launched_q, launched_d;
   logic                  valid_q, valid_d;
   logic [INSTR_SIZE-1:0] instr_q, instr_d;
   logic [XLEN-1:0]       opc_q, opc_d;

   logic                  consumed, req, ack;
   logic [XLEN-1:0]       im_addr, redirect_tgt, pc_inc;
   logic                  skid_load, skid_unload, skid_full;
   logic [INSTR_SIZE-1:0] skid_instr;
   logic [XLEN-1:0]       skid_pc;

   // Masking rather than slicing keeps every target bit referenced.
   assign redirect_tgt = i_Redirect_PC & ~XLEN'(3);
   assign pc_inc       = pc_q + XLEN'(4);

   always_comb begin
      consumed = !valid_q || !i_Stall;

      // A request launches in REQ only when the output can take it; once
      // launched it stays up until acked. DROP keeps the stale request up.
      req = 1'b0;
      if (!i_rst) begin
         unique case (state_q)
            ST_REQ:  req = launched_q || consumed;
            ST_DROP: req = 1'b1;
            default: req = 1'b0;
         endcase
      end
      ack     = req && i_IM_ack;
      im_addr = (state_q == ST_DROP) ? drop_pc_q : pc_q;

      state_d     = state_q;
      pc_d        = pc_q;
      drop_pc_d   = drop_pc_q;
      launched_d  = launched_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      opc_d       = opc_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;

      if (i_Redirect) begin
         valid_d    = 1'b0;
         instr_d    = NOP_INSTR;
         opc_d      = redirect_tgt;
         pc_d       = redirect_tgt;
         launched_d = 1'b0;
         // A request still in flight must be waited out at its old address.
         if (req && !ack) begin
            state_d   = ST_DROP;
            drop_pc_d = im_addr;
         end else begin
            state_d = ST_REQ;
         end
      end else begin
         unique case (state_q)
            ST_REQ: begin
               launched_d = req && !ack;
               if (ack) begin
                  pc_d = pc_inc;
                  if (consumed) begin
                     valid_d = 1'b1;
                     instr_d = i_IM_data;
                     opc_d   = pc_q;
                  end else begin
                     skid_load = 1'b1;
                     state_d   = ST_FULL;
                  end
               end
            end
            ST_FULL: begin
               if (skid_full && !i_Stall) begin
                  valid_d     = 1'b1;
                  instr_d     = skid_instr;
                  opc_d       = skid_pc;
                  skid_unload = 1'b1;
                  state_d     = ST_REQ;
               end
            end
            ST_DROP: begin
               if (ack) begin
                  state_d    = ST_REQ;
                  launched_d = 1'b0;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         launched_q <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         opc_q      <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         launched_q <= launched_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         opc_q      <= opc_d;
      end
   end

   // Stale address is only read in DROP, which always loads it first.
   always_ff @(posedge i_clk) begin
      drop_pc_q <= drop_pc_d;
   end

   fetch_skid_buf #(
      .XLEN (XLEN)
   ) u_skid (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (skid_load),
      .i_unload (skid_unload),
      .i_clear  (i_Redirect),
      .i_instr  (i_IM_data),
      .i_pc     (pc_q),
      .o_full   (skid_full),
      .o_instr  (skid_instr),
      .o_pc     (skid_pc)
   );

   assign o_IM_req  = req;
   assign o_IM_addr = im_addr;
   assign o_Instr   = instr_q;
   assign o_PC      = opc_q;
   assign o_Valid   = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] rpc;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory model: ack after mem_lat waiting cycles while mem_en is set.
   logic mem_en;
   int   mem_lat;
   int   wait_cnt;

   logic [31:0] exp_q[$];
   logic        prev_v;
   logic [31:0] prev_pc;

   instr_fetch dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_Stall       (stall),
      .i_Redirect    (redirect),
      .i_Redirect_PC (rpc),
      .o_IM_req      (im_req),
      .o_IM_addr     (im_addr),
      .i_IM_ack      (im_ack),
      .i_IM_data     (im_data),
      .o_Instr       (instr),
      .o_PC          (pc),
      .o_Valid       (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0033;
   endfunction

   assign im_ack  = im_req && mem_en && (wait_cnt >= mem_lat);
   assign im_data = mem_word(im_addr);

   always @(posedge clk) begin
      if (rst || !im_req || im_ack) wait_cnt <= 0;
      else                          wait_cnt <= wait_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every newly presented instruction must be the next expected one.
   always @(negedge clk) begin
      if (rst) begin
         prev_v <= 1'b0;
      end else begin
         if (valid && (!prev_v || pc != prev_pc)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $error("FAIL sb_extra observed_pc=%h expected=none", pc);
            end else begin
               chk("sb_pc", pc, exp_q[0]);
               chk("sb_instr", instr, mem_word(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
         prev_v  <= valid;
         prev_pc <= pc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      stall    = 1'b0;
      redirect = 1'b0;
      rpc      = '0;
      mem_en   = 1'b0;
      mem_lat  = 0;
      step();
      step();
   endtask

   initial begin
      // Reset state and zero-wait streaming
      do_reset();
      @(negedge clk);
      chk("rst_req", 32'(im_req), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_pc", pc, 32'h0);
      step(); rst = 1'b0; mem_en = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      @(negedge clk);
      chk("zw_first_req", 32'(im_req), 32'd1);
      chk("zw_first_addr", im_addr, 32'h0);
      step(); @(negedge clk);
      chk("zw_valid_c2", 32'(valid), 32'd1);
      chk("zw_pc0", pc, 32'h0);
      step(); @(negedge clk);
      chk("zw_pc4", pc, 32'h4);
      step(); mem_en = 1'b0; @(negedge clk);
      chk("zw_pc8", pc, 32'h8);
      step();
      chk("zw_sb_empty", 32'(exp_q.size()), 32'd0);

      // Ack delayed by 3 cycles
      do_reset();
      step(); rst = 1'b0; mem_en = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      step(); mem_lat = 3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("dl_req_held", 32'(im_req), 32'd1);
         chk("dl_addr_held", im_addr, 32'h4);
         chk("dl_pc_hold", pc, 32'h0);
         step();
      end
      @(negedge clk);
      chk("dl_pc_before_ack", pc, 32'h0);
      step(); mem_en = 1'b0; @(negedge clk);
      chk("dl_pc_after", pc, 32'h4);
      chk("dl_instr_after", instr, mem_word(32'h4));
      step();
      chk("dl_sb_empty", 32'(exp_q.size()), 32'd0);

      // Stall for 4 cycles while the request to 0x8 completes
      do_reset();
      step(); rst = 1'b0; mem_en = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      step();
      step(); mem_lat = 2; @(negedge clk);
      chk("st_launch_addr", im_addr, 32'h8);
      step(); stall = 1'b1; @(negedge clk);
      chk("st_pc_d", pc, 32'h4);
      chk("st_req_d", 32'(im_req), 32'd1);
      step(); @(negedge clk);
      chk("st_addr_e", im_addr, 32'h8);
      chk("st_pc_e", pc, 32'h4);
      step(); @(negedge clk);
      chk("st_full_req", 32'(im_req), 32'd0);
      chk("st_pc_f", pc, 32'h4);
      chk("st_valid_f", 32'(valid), 32'd1);
      step(); @(negedge clk);
      chk("st_full_req2", 32'(im_req), 32'd0);
      step(); stall = 1'b0; mem_en = 1'b0; @(negedge clk);
      chk("st_rel_pc_hold", pc, 32'h4);
      step(); @(negedge clk);
      chk("st_rel_pc", pc, 32'h8);
      chk("st_rel_instr", instr, mem_word(32'h8));
      step();
      chk("st_sb_empty", 32'(exp_q.size()), 32'd0);

      // Redirect to 0x100 while the request to 0x10 is outstanding
      do_reset();
      step(); rst = 1'b0; mem_en = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      exp_q.push_back(32'hC); exp_q.push_back(32'h100);
      step(); step(); step();
      step(); mem_en = 1'b0; @(negedge clk);
      chk("rd_out_addr", im_addr, 32'h10);
      step(); redirect = 1'b1; rpc = 32'h100;
      step(); redirect = 1'b0; mem_en = 1'b1; @(negedge clk);
      chk("rd_valid0", 32'(valid), 32'd0);
      chk("rd_instr_nop", instr, 32'h0000_0013);
      chk("rd_stale_addr", im_addr, 32'h10);
      step(); @(negedge clk);
      chk("rd_new_addr", im_addr, 32'h100);
      chk("rd_valid_still0", 32'(valid), 32'd0);
      step(); mem_en = 1'b0; @(negedge clk);
      chk("rd_tgt_pc", pc, 32'h100);
      step();
      chk("rd_sb_empty", 32'(exp_q.size()), 32'd0);

      // Redirect coincident with ack and with stall
      do_reset();
      step(); rst = 1'b0; mem_en = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h300);
      step();
      step(); mem_lat = 1; @(negedge clk);
      chk("rc_launch_addr", im_addr, 32'h8);
      step(); stall = 1'b1; redirect = 1'b1; rpc = 32'h300; @(negedge clk);
      chk("rc_ack_cycle", 32'(im_ack), 32'd1);
      step(); redirect = 1'b0; @(negedge clk);
      chk("rc_valid0", 32'(valid), 32'd0);
      chk("rc_pc_tgt", pc, 32'h300);
      chk("rc_instr_nop", instr, 32'h0000_0013);
      chk("rc_req_tgt", im_addr, 32'h300);
      step();
      step(); mem_en = 1'b0; @(negedge clk);
      chk("rc_tgt_valid", 32'(valid), 32'd1);
      chk("rc_tgt_instr", instr, mem_word(32'h300));
      chk("rc_stalled_noreq", 32'(im_req), 32'd0);
      step(); stall = 1'b0;
      chk("rc_sb_empty", 32'(exp_q.size()), 32'd0);

      // Unaligned redirect target, then reset mid-request
      do_reset();
      step(); rst = 1'b0;
      exp_q.push_back(32'h200);
      @(negedge clk);
      chk("ua_first_addr", im_addr, 32'h0);
      step(); redirect = 1'b1; rpc = 32'h203;
      step(); redirect = 1'b0; mem_en = 1'b1; @(negedge clk);
      chk("ua_stale_addr", im_addr, 32'h0);
      step(); @(negedge clk);
      chk("ua_aligned_addr", im_addr, 32'h200);
      step(); mem_en = 1'b0; @(negedge clk);
      chk("ua_pc", pc, 32'h200);
      step(); rst = 1'b1; @(negedge clk);
      chk("mr_req_in_rst", 32'(im_req), 32'd0);
      step(); @(negedge clk);
      chk("mr_valid", 32'(valid), 32'd0);
      chk("mr_instr", instr, 32'h0000_0013);
      chk("mr_pc", pc, 32'h0);
      step(); rst = 1'b0; @(negedge clk);
      chk("mr_first_req", 32'(im_req), 32'd1);
      chk("mr_first_addr", im_addr, 32'h0);
      chk("ua_sb_empty", 32'(exp_q.size()), 32'd0);

      // PC wraps past the top of the address space
      exp_q.push_back(32'hFFFF_FFFC);
      step(); redirect = 1'b1; rpc = 32'hFFFF_FFFC;
      step(); redirect = 1'b0; mem_en = 1'b1;
      step(); @(negedge clk);
      chk("wr_addr_top", im_addr, 32'hFFFF_FFFC);
      step(); mem_en = 1'b0; @(negedge clk);
      chk("wr_pc_top", pc, 32'hFFFF_FFFC);
      chk("wr_addr_wrap", im_addr, 32'h0);
      step();
      chk("wr_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
